wb_trace_buffer: RTL and testbench

Writeback-stage observer for the pipelined RISC-V core. It sits on the W-stage outputs of `Pipeline_top` (RegWriteW, RDW, ResultW) and captures every architectural register write into a FIFO. It exposes the writes in retirement order on a valid/ready read port, for a debug host, a self-checking bench, or an on-chip comparator. Where the core only produces the writeback stream, this block consumes it: it buffers and counts the stream, and flags overflow.

---
 rtl/wb_trace_buffer.sv | 123 ++++++++++++
 tb/tb_wb_trace_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures W-stage register writes (x0 excluded) into a
// first-word fall-through FIFO. Optional signature register under `WB_TRACE_SIG_EN.
module wb_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RegWriteW,
    input  logic [4:0]                 RDW,
    input  logic [31:0]                ResultW,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [4:0]                 trace_rd,
    output logic [31:0]                trace_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           wb_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic [31:0]                sig
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [36:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic [CNT_W-1:0] r_wb_count;
    logic [CNT_W-1:0] r_drop_count;

    logic w_cap;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic [36:0] w_head;

    // Valid/ready: an entry transfers on any rising edge where trace_valid and
    // trace_ready are both 1; the head is held steady until that happens.
    assign w_cap   = RegWriteW && (RDW != 5'd0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && trace_ready;
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_drop  = w_cap && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage is never reset; the level alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= {RDW, ResultW};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Event counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow   <= 1'b0;
            r_wb_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_cap && (r_wb_count != '1)) begin
                r_wb_count <= r_wb_count + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + CNT_W'(1);
                end
            end
        end
    end

`ifdef WB_TRACE_SIG_EN
    logic [31:0] r_sig;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sig <= '0;
        end else if (w_push) begin
            r_sig <= {r_sig[30:0], r_sig[31]} ^ ResultW ^ {27'b0, RDW};
        end
    end

    assign sig = r_sig;
`else
    assign sig = 32'h0;
`endif

    assign trace_valid = !w_empty;
    assign trace_rd    = w_head[36:32];
    assign trace_data  = w_head[31:0];
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign wb_count    = r_wb_count;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed and random bench for wb_trace_buffer with an expected-entry queue.
// Follows `WB_TRACE_SIG_EN the same way as the design build.
module tb_wb_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             RegWriteW = 1'b0;
  logic [4:0]       RDW = '0;
  logic [31:0]      ResultW = '0;
  logic             trace_ready = 1'b0;
  logic             trace_valid;
  logic [4:0]       trace_rd;
  logic [31:0]      trace_data;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [CNT_W-1:0] wb_count;
  logic [CNT_W-1:0] drop_count;
  logic [31:0]      sig;

  wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .RegWriteW(RegWriteW),
    .RDW(RDW),
    .ResultW(ResultW),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_rd(trace_rd),
    .trace_data(trace_data),
    .level(level),
    .overflow(overflow),
    .wb_count(wb_count),
    .drop_count(drop_count),
    .sig(sig)
  );

  always #5 clk = ~clk;

  logic [36:0]      exp_q[$];
  logic [CNT_W-1:0] m_wb;
  logic [CNT_W-1:0] m_drop;
  logic             m_ovf;
  logic [31:0]      m_sig;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_wb   = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
    m_sig  = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_valid"}, trace_valid, exp_q.size() != 0);
    chk({tag, "_level"}, level, exp_q.size());
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_wb"}, wb_count, m_wb);
    chk({tag, "_drop"}, drop_count, m_drop);
    chk({tag, "_sig"}, sig, m_sig);
  endtask

  // One clock of stimulus; called just after a falling edge.
  task automatic cycle(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                       input logic rdy);
    logic cap, full, pop, push;
    RegWriteW   = rw;
    RDW         = rd;
    ResultW     = res;
    trace_ready = rdy;
    #1;
    chk("valid_pre", trace_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("head", {trace_rd, trace_data}, exp_q[0]);
    cap  = rw && (rd != 5'd0);
    full = (exp_q.size() == DEPTH);
    pop  = (exp_q.size() != 0) && rdy;
    push = cap && (!full || pop);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({rd, res});
`ifdef WB_TRACE_SIG_EN
      m_sig = {m_sig[30:0], m_sig[31]} ^ res ^ {27'b0, rd};
`endif
    end
    if (cap && full && !pop) begin
      m_ovf = 1'b1;
      if (m_drop != '1) m_drop = m_drop + 1'b1;
    end
    if (cap && (m_wb != '1)) m_wb = m_wb + 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic rw, input logic [4:0] rd);
    rst         = 1'b0;
    RegWriteW   = rw;
    RDW         = rd;
    ResultW     = $urandom;
    trace_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_clear();
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    @(negedge clk);

    // Reset and idle
    do_reset(2, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    check_state("idle");

    // Single capture, then signature pair
    cycle(1'b1, 5'd5, 32'h0000_000A, 1'b0);
    check_state("cap1");
    chk("cap1_rd", trace_rd, 5'd5);
    chk("cap1_data", trace_data, 32'hA);
`ifdef WB_TRACE_SIG_EN
    chk("sig_first", sig, 32'hF);
`else
    chk("sig_first", sig, 32'h0);
`endif
    cycle(1'b1, 5'd6, 32'h0000_0014, 1'b0);
    check_state("cap2");
`ifdef WB_TRACE_SIG_EN
    chk("sig_second", sig, 32'hC);
`else
    chk("sig_second", sig, 32'h0);
`endif

    // x0 filter
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    check_state("x0");
    chk("x0_wb", wb_count, 2);

    // Drain, including a simultaneous capture on a non-empty FIFO
    cycle(1'b1, 5'd9, 32'h1234_5678, 1'b1);
    check_state("pp");
    repeat (3) cycle(1'b0, 5'd0, 32'h0, 1'b1);
    check_state("drain0");

    // Empty FIFO with capture and ready both high
    cycle(1'b1, 5'd3, 32'hCAFE_0003, 1'b1);
    check_state("empty_cap_rdy");
    chk("empty_cap_rdy_lvl", level, 1);
    cycle(1'b0, 5'd0, 32'h0, 1'b1);

    // Overflow sequence
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 5'(i), $urandom, 1'b0);
    check_state("fill");
    chk("fill_lvl", level, DEPTH);
    cycle(1'b1, 5'd20, 32'hDEAD_0009, 1'b0);
    check_state("drop");
    chk("drop_cnt", drop_count, 1);
    chk("drop_ovf", overflow, 1'b1);
    cycle(1'b1, 5'd21, 32'hBEEF_000A, 1'b1);
    check_state("full_pp");
    chk("full_pp_lvl", level, DEPTH);
    chk("full_pp_drop", drop_count, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 5'd0, 32'h0, 1'b1);
    check_state("drained");
    chk("drained_ovf", overflow, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 2) == 0);
      if (i % 25 == 0) check_state("rand");
    end
    while (exp_q.size() != 0) cycle(1'b0, 5'd0, 32'h0, 1'b1);
    check_state("rand_end");

    // Reset mid-operation with level 3 and overflow set
    if (!m_ovf) begin
      for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 5'd1, $urandom, 1'b0);
      while (exp_q.size() != 0) cycle(1'b0, 5'd0, 32'h0, 1'b1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'(10 + i), $urandom, 1'b0);
    check_state("pre_rst");
    chk("pre_rst_lvl", level, 3);
    do_reset(1, 1'b1, 5'd7);
    RegWriteW = 1'b0;
    #1;
    check_state("mid_rst");
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_wb", wb_count, 0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    check_state("post_rst");
    cycle(1'b1, 5'd31, 32'h5555_AAAA, 1'b0);
    check_state("post_rst_cap");
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
